// File: rtl/rv32_hart_pc_sched_if.sv
// Fetch-offer and resolve bus between the barrel-hart PC scheduler and the pipeline.
//   master : scheduler side, drives the registered fetch offer and consumes resolves
//   slave  : pipeline side, accepts offers (fetch_ready) and returns next-PC results
// Signals:
//   fetch_valid/fetch_hart/fetch_pc          offer from scheduler
//   fetch_ready                              fetch stage accepts the offer this cycle
//   resolve_valid/resolve_hart               next-PC result for a hart in flight
//   resolve_has_new_pc/resolve_pc            redirect flag and target
interface rv32_hart_pc_sched_if #(
    parameter int unsigned NUM_HARTS = 8
);
    localparam int unsigned HW = $clog2(NUM_HARTS);

    logic          fetch_valid;
    logic          fetch_ready;
    logic [HW-1:0] fetch_hart;
    logic [31:0]   fetch_pc;
    logic          resolve_valid;
    logic [HW-1:0] resolve_hart;
    logic          resolve_has_new_pc;
    logic [31:0]   resolve_pc;

    modport master (
        output fetch_valid, fetch_hart, fetch_pc,
        input  fetch_ready, resolve_valid, resolve_hart, resolve_has_new_pc, resolve_pc
    );

    modport slave (
        input  fetch_valid, fetch_hart, fetch_pc,
        output fetch_ready, resolve_valid, resolve_hart, resolve_has_new_pc, resolve_pc
    );
endinterface

// File: rtl/rv32_hart_pc_sched.sv
// Barrel-hart PC scheduler. Keeps one PC and a READY/OFFERED/IN_FLIGHT state per hart,
// presents one registered fetch offer at a time chosen round-robin among enabled READY
// harts, and updates a hart's PC when the execute stage resolves its instruction.
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   hart_en      per-hart issue enable (only gates selection, never resolves)
//   bus          fetch offer / resolve interface (master modport)
//   misalign     one-cycle pulse after an applied redirect whose target had bits[1:0] != 0
//   proto_err    sticky flag: resolve arrived for a hart that was not in flight
module rv32_hart_pc_sched #(
    parameter int unsigned NUM_HARTS      = 8,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] HART_PC_STRIDE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_HARTS-1:0] hart_en,
    rv32_hart_pc_sched_if.master bus,
    output logic                 misalign,
    output logic                 proto_err
);
    localparam int unsigned HW = $clog2(NUM_HARTS);

    typedef enum logic [1:0] {StReady, StOffered, StInFlight} hart_state_e;

    hart_state_e   state_q [NUM_HARTS];
    hart_state_e   state_d [NUM_HARTS];
    logic [31:0]   pc_q    [NUM_HARTS];
    logic [31:0]   pc_d    [NUM_HARTS];
    logic [HW-1:0] rr_ptr_q, rr_ptr_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic [HW-1:0] fetch_hart_q, fetch_hart_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          misalign_q, misalign_d;
    logic          proto_err_q, proto_err_d;

    logic          accept;
    logic          load;
    logic          sel_found;
    logic [HW-1:0] sel_hart;
    logic [HW-1:0] scan_idx;

    assign accept = fetch_valid_q & bus.fetch_ready;
    assign load   = ~fetch_valid_q | bus.fetch_ready;

    // Round-robin scan from rr_ptr_q. Uses registered state only, so a hart resolved
    // this cycle cannot be picked until the next one.
    always_comb begin
        sel_found = 1'b0;
        sel_hart  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            scan_idx = rr_ptr_q + HW'(i);
            if (!sel_found && (state_q[scan_idx] == StReady) && hart_en[scan_idx]) begin
                sel_found = 1'b1;
                sel_hart  = scan_idx;
            end
        end
    end

    // Resolve, accept and load touch disjoint harts (IN_FLIGHT, OFFERED, READY
    // respectively), so their updates never collide.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rr_ptr_d      = rr_ptr_q;
        fetch_valid_d = fetch_valid_q;
        fetch_hart_d  = fetch_hart_q;
        fetch_pc_d    = fetch_pc_q;
        misalign_d    = 1'b0;
        proto_err_d   = proto_err_q;

        if (bus.resolve_valid) begin
            if (state_q[bus.resolve_hart] == StInFlight) begin
                state_d[bus.resolve_hart] = StReady;
                if (bus.resolve_has_new_pc) begin
                    pc_d[bus.resolve_hart] = {bus.resolve_pc[31:2], 2'b00};
                    misalign_d             = |bus.resolve_pc[1:0];
                end else begin
                    pc_d[bus.resolve_hart] = pc_q[bus.resolve_hart] + 32'd4;
                end
            end else begin
                proto_err_d = 1'b1;
            end
        end

        if (accept) begin
            state_d[fetch_hart_q] = StInFlight;
            rr_ptr_d              = fetch_hart_q + HW'(1);
        end

        if (load) begin
            fetch_valid_d = sel_found;
            if (sel_found) begin
                fetch_hart_d      = sel_hart;
                fetch_pc_d        = pc_q[sel_hart];
                state_d[sel_hart] = StOffered;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                pc_q[h]    <= RESET_PC + HART_PC_STRIDE * 32'(h);
                state_q[h] <= StReady;
            end
            rr_ptr_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_hart_q  <= '0;
            fetch_pc_q    <= '0;
            misalign_q    <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_hart_q  <= fetch_hart_d;
            fetch_pc_q    <= fetch_pc_d;
            misalign_q    <= misalign_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_hart  = fetch_hart_q;
    assign bus.fetch_pc    = fetch_pc_q;
    assign misalign        = misalign_q;
    assign proto_err       = proto_err_q;
endmodule

// File: tb/tb_rv32_hart_pc_sched.sv
// Bench for rv32_hart_pc_sched: a fixed vector table, hand-written corner sequences and
// a randomized run, all also compared every cycle against a behavioural model.
module tb_rv32_hart_pc_sched;
    localparam int unsigned N  = 8;
    localparam int unsigned HW = $clog2(N);
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] STRIDE = 32'h0000_0000;
    localparam int M_READY = 0;
    localparam int M_OFFER = 1;
    localparam int M_FLY   = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] hart_en;
    logic         misalign;
    logic         proto_err;

    rv32_hart_pc_sched_if #(.NUM_HARTS(N)) sb ();

    rv32_hart_pc_sched #(
        .NUM_HARTS(N),
        .RESET_PC(RST_PC),
        .HART_PC_STRIDE(STRIDE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hart_en(hart_en),
        .bus(sb),
        .misalign(misalign),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    int          m_state [N];
    logic [31:0] m_pc    [N];
    bit          m_valid;
    int          m_hart;
    logic [31:0] m_opc;
    int          m_rr;
    bit          m_mis;
    bit          m_perr;

    typedef struct {
        logic        rst;
        logic [7:0]  en;
        logic        rdy;
        logic        rv;
        int          rh;
        logic        newpc;
        logic [31:0] rpc;
        logic        ev;
        int          eh;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step();
        int  nst [N];
        int  old_rr;
        bit  was_valid;
        bit  found;
        if (rst) begin
            for (int h = 0; h < N; h++) begin
                m_pc[h]    = RST_PC + STRIDE * h;
                m_state[h] = M_READY;
            end
            m_valid = 0; m_hart = 0; m_opc = 0; m_rr = 0; m_mis = 0; m_perr = 0;
            return;
        end
        nst       = m_state;
        old_rr    = m_rr;
        was_valid = m_valid;
        m_mis     = 0;
        if (sb.resolve_valid) begin
            int h = int'(sb.resolve_hart);
            if (m_state[h] == M_FLY) begin
                nst[h] = M_READY;
                if (sb.resolve_has_new_pc) begin
                    m_pc[h] = sb.resolve_pc & 32'hFFFF_FFFC;
                    m_mis   = (sb.resolve_pc % 4) != 0;
                end else begin
                    m_pc[h] = m_pc[h] + 32'd4;
                end
            end else begin
                m_perr = 1;
            end
        end
        if (was_valid && sb.fetch_ready) begin
            nst[m_hart] = M_FLY;
            m_rr        = (m_hart + 1) % N;
        end
        if (!was_valid || sb.fetch_ready) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                int h = (old_rr + i) % N;
                if (!found && m_state[h] == M_READY && hart_en[h]) begin
                    found  = 1;
                    m_hart = h;
                    m_opc  = m_pc[h];
                    nst[h] = M_OFFER;
                end
            end
            m_valid = found;
        end
        m_state = nst;
    endtask

    task automatic cmp_model();
        chk("model.fetch_valid", 32'(sb.fetch_valid), 32'(m_valid));
        if (m_valid) begin
            chk("model.fetch_hart", 32'(sb.fetch_hart), m_hart);
            chk("model.fetch_pc", sb.fetch_pc, m_opc);
        end
        chk("model.misalign", 32'(misalign), 32'(m_mis));
        chk("model.proto_err", 32'(proto_err), 32'(m_perr));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic set_res(input bit v, input int h, input bit np, input logic [31:0] pc);
        sb.resolve_valid      = v;
        sb.resolve_hart       = HW'(h);
        sb.resolve_has_new_pc = np;
        sb.resolve_pc         = pc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.fetch_ready = 1'b0;
        set_res(0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hart_en = '0;
        sb.fetch_ready = 1'b0;
        set_res(0, 0, 0, 0);

        // Boot sequence: all harts enabled, each resolved the cycle after its accept
        tbl[0]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b0, 0, 32'h0};
        tbl[1]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b1, 0, 32'h0};
        tbl[2]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 32'h0, 1'b1, 1, 32'h0};
        tbl[3]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 0, 1'b0, 32'h0, 1'b1, 2, 32'h0};
        tbl[4]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1, 1'b0, 32'h0, 1'b1, 3, 32'h0};
        tbl[5]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 2, 1'b0, 32'h0, 1'b1, 4, 32'h0};
        tbl[6]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 3, 1'b0, 32'h0, 1'b1, 5, 32'h0};
        tbl[7]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 4, 1'b0, 32'h0, 1'b1, 6, 32'h0};
        tbl[8]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 5, 1'b0, 32'h0, 1'b1, 7, 32'h0};
        tbl[9]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 6, 1'b0, 32'h0, 1'b1, 0, 32'h4};
        tbl[10] = '{1'b0, 8'hFF, 1'b1, 1'b1, 7, 1'b0, 32'h0, 1'b1, 1, 32'h4};

        for (int i = 0; i < 11; i++) begin
            rst            = tbl[i].rst;
            hart_en        = tbl[i].en;
            sb.fetch_ready = tbl[i].rdy;
            set_res(tbl[i].rv, tbl[i].rh, tbl[i].newpc, tbl[i].rpc);
            step();
            chk($sformatf("tbl[%0d].valid", i), 32'(sb.fetch_valid), 32'(tbl[i].ev));
            if (tbl[i].ev || tbl[i].rst) begin
                chk($sformatf("tbl[%0d].hart", i), 32'(sb.fetch_hart), tbl[i].eh);
                chk($sformatf("tbl[%0d].pc", i), sb.fetch_pc, tbl[i].epc);
            end
            chk($sformatf("tbl[%0d].misalign", i), 32'(misalign), 32'h0);
            chk($sformatf("tbl[%0d].proto_err", i), 32'(proto_err), 32'h0);
        end

        // Single enabled hart: idle until its resolve, offered the cycle after
        do_reset();
        hart_en = 8'h04;
        sb.fetch_ready = 1'b1;
        step();
        chk("solo.first_hart", 32'(sb.fetch_hart), 32'd2);
        chk("solo.first_pc", sb.fetch_pc, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("solo.after_accept", 32'(sb.fetch_valid), 32'd0);
            set_res(1, 2, 0, 0);
            step();
            chk("solo.resolve_cycle", 32'(sb.fetch_valid), 32'd0);
            set_res(0, 0, 0, 0);
            step();
            chk("solo.reoffer_valid", 32'(sb.fetch_valid), 32'd1);
            chk("solo.reoffer_pc", sb.fetch_pc, 32'(4 * k));
        end

        // Stall with hart_en[2] dropped: offer must stay put, others not stolen
        sb.fetch_ready = 1'b0;
        hart_en = 8'hFB;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall.valid", 32'(sb.fetch_valid), 32'd1);
            chk("stall.hart", 32'(sb.fetch_hart), 32'd2);
            chk("stall.pc", sb.fetch_pc, 32'h10);
        end
        sb.fetch_ready = 1'b1;
        step();
        chk("stall.next_hart", 32'(sb.fetch_hart), 32'd3);
        chk("stall.next_pc", sb.fetch_pc, 32'h0);

        // Misaligned redirect on hart 3
        hart_en = 8'h08;
        step();
        chk("redir.idle", 32'(sb.fetch_valid), 32'd0);
        set_res(1, 3, 1, 32'h0000_0102);
        step();
        chk("redir.misalign_pulse", 32'(misalign), 32'd1);
        set_res(0, 0, 0, 0);
        step();
        chk("redir.misalign_clear", 32'(misalign), 32'd0);
        chk("redir.hart", 32'(sb.fetch_hart), 32'd3);
        chk("redir.pc", sb.fetch_pc, 32'h100);

        // Resolve for a READY hart: ignored, sticky error
        sb.fetch_ready = 1'b0;
        set_res(1, 5, 1, 32'h40);
        step();
        chk("proto.set", 32'(proto_err), 32'd1);
        set_res(0, 0, 0, 0);
        hart_en = 8'h20;
        sb.fetch_ready = 1'b1;
        step();
        chk("proto.hart5", 32'(sb.fetch_hart), 32'd5);
        chk("proto.pc_unchanged", sb.fetch_pc, 32'h0);
        sb.fetch_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("proto.sticky", 32'(proto_err), 32'd1);
        end
        rst = 1'b1;
        step();
        chk("proto.cleared", 32'(proto_err), 32'd0);
        chk("proto.rst_valid", 32'(sb.fetch_valid), 32'd0);

        // PC wrap, then reset in the middle of a stall
        rst = 1'b0;
        hart_en = 8'h01;
        sb.fetch_ready = 1'b1;
        step();
        step();
        set_res(1, 0, 1, 32'hFFFF_FFFC);
        step();
        set_res(0, 0, 0, 0);
        step();
        chk("wrap.top_pc", sb.fetch_pc, 32'hFFFF_FFFC);
        step();
        set_res(1, 0, 0, 0);
        step();
        set_res(0, 0, 0, 0);
        step();
        chk("wrap.valid", 32'(sb.fetch_valid), 32'd1);
        chk("wrap.pc", sb.fetch_pc, 32'h0);
        chk("wrap.no_err", 32'(proto_err), 32'd0);
        sb.fetch_ready = 1'b0;
        hart_en = 8'hFF;
        step();
        rst = 1'b1;
        step();
        chk("midrst.valid", 32'(sb.fetch_valid), 32'd0);
        chk("midrst.pc", sb.fetch_pc, 32'h0);
        rst = 1'b0;
        sb.fetch_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            step();
            chk("midrst.order", 32'(sb.fetch_hart), i);
            chk("midrst.reset_pc", sb.fetch_pc, RST_PC + STRIDE * i);
        end
        sb.fetch_ready = 1'b0;
        set_res(1, 7, 0, 0);
        step();
        chk("midrst.late_resolve", 32'(proto_err), 32'd1);
        set_res(0, 0, 0, 0);

        // Randomized run against the model
        do_reset();
        hart_en = N'($urandom);
        for (int c = 0; c < 2000; c++) begin
            int fly [$];
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) hart_en = N'($urandom);
            sb.fetch_ready = ($urandom_range(0, 3) != 0);
            set_res(0, 0, 0, 0);
            for (int h = 0; h < N; h++) if (m_state[h] == M_FLY) fly.push_back(h);
            if ($urandom_range(0, 149) == 0) begin
                set_res(1, int'($urandom_range(0, N - 1)), 0, 0);
            end else if (fly.size() > 0 && $urandom_range(0, 1) == 1) begin
                set_res(1, fly[$urandom_range(0, fly.size() - 1)],
                        ($urandom_range(0, 2) == 0), $urandom);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
